formula_nest_fsm: RTL and testbench

- Computes a parametrised chain of square roots over N input words, sequencing all work through one shared external isqrt unit.
- Mode 0 (nested): res = isqrt(x0 + isqrt(x1 + ... + isqrt(x[N-1]))).
- Mode 1 (sum): res = isqrt(x0) + isqrt(x1) + ... + isqrt(x[N-1]).
- Successor of the fixed three-argument nested-formula FSM, adding argument count, width, mode select and an arg_rdy handshake.

---
 rtl/formula_nest_fsm.sv | 113 +++++++++++
 tb/tb_formula_nest_fsm.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/formula_nest_fsm.sv
// formula_nest_fsm: evaluates a chain of integer square roots over N argument
// words, either nested (isqrt(x0 + isqrt(x1 + ... isqrt(x[N-1])))) or summed
// (isqrt(x0) + ... + isqrt(x[N-1])), using one shared external isqrt unit.
// Arguments are consumed from the highest index down to x0, one isqrt
// request in flight at a time.
module formula_nest_fsm #(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           arg_vld,
    output logic           arg_rdy,
    input  logic           mode,
    input  logic [N*W-1:0] args,
    output logic           res_vld,
    output logic [W-1:0]   res,
    output logic           isqrt_x_vld,
    output logic [W-1:0]   isqrt_x,
    input  logic           isqrt_y_vld,
    input  logic [W/2-1:0] isqrt_y
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [W-1:0]   acc;
    logic [N*W-1:0] args_q;
    logic           mode_q;

    logic           accept;
    logic           step;
    logic [W-1:0]   y_ext;
    logic [W-1:0]   next_arg;
    logic [IW-1:0]  idx_dec;

    assign arg_rdy = (state == IDLE);
    assign accept  = arg_vld && arg_rdy;
    assign y_ext   = {{(W/2){1'b0}}, isqrt_y};
    assign idx_dec = idx - IW'(1);
    // A response that is not the last one immediately triggers the next request.
    assign step    = (state == WAIT) && isqrt_y_vld && (idx != '0);

    // Pick the latched argument that feeds the next request (x[idx-1]).
    always_comb begin
        next_arg = '0;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == idx_dec) begin
                next_arg = args_q[i*W +: W];
            end
        end
    end

    // Drive the isqrt request: top argument on accept, otherwise the next argument (plus the previous root when nested).
    always_comb begin
        isqrt_x_vld = accept || step;
        if (accept) begin
            isqrt_x = args[(N-1)*W +: W];
        end else if (mode_q) begin
            isqrt_x = next_arg;
        end else begin
            isqrt_x = next_arg + y_ext;
        end
    end

    // Sequencer: latch a new argument set, walk the index down on each response, publish the result on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            acc     <= '0;
            args_q  <= '0;
            mode_q  <= 1'b0;
            res_vld <= 1'b0;
            res     <= '0;
        end else begin
            res_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (arg_vld) begin
                        args_q <= args;
                        mode_q <= mode;
                        idx    <= LAST_IDX;
                        acc    <= '0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (isqrt_y_vld) begin
                        if (idx != '0) begin
                            if (mode_q) begin
                                acc <= acc + y_ext;
                            end
                            idx <= idx_dec;
                        end else begin
                            res_vld <= 1'b1;
                            res     <= mode_q ? (acc + y_ext) : y_ext;
                            state   <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_formula_nest_fsm.sv
// Testbench for formula_nest_fsm: drives an N=3 and an N=1 instance, each
// served by a behavioural isqrt unit with programmable latency, and compares
// results, request sequences and latency with a reference model that
// evaluates the formulas directly.
module tb_formula_nest_fsm;

    logic        clk = 1'b0;
    logic        rst;

    logic        arg_vld3, mode3, arg_rdy3, res_vld3, xv3;
    logic        yv3 = 1'b0;
    logic [95:0] args3;
    logic [31:0] res3, x3;
    logic [15:0] y3 = '0;

    logic        arg_vld1, mode1, arg_rdy1, res_vld1, xv1;
    logic        yv1 = 1'b0;
    logic [31:0] args1;
    logic [31:0] res1, x1;
    logic [15:0] y1 = '0;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          t_acc = 0;

    int          lat3 = 1, lat1 = 1;
    logic        pend3 = 1'b0, pend1 = 1'b0;
    int          due3 = 0, due1 = 0;
    logic [15:0] val3 = '0, val1 = '0;
    logic [31:0] req_log3 [8];
    int          req_cnt3 = 0;

    formula_nest_fsm #(.N(3), .W(32)) dut3 (
        .clk(clk), .rst(rst),
        .arg_vld(arg_vld3), .arg_rdy(arg_rdy3), .mode(mode3), .args(args3),
        .res_vld(res_vld3), .res(res3),
        .isqrt_x_vld(xv3), .isqrt_x(x3), .isqrt_y_vld(yv3), .isqrt_y(y3)
    );

    formula_nest_fsm #(.N(1), .W(32)) dut1 (
        .clk(clk), .rst(rst),
        .arg_vld(arg_vld1), .arg_rdy(arg_rdy1), .mode(mode1), .args(args1),
        .res_vld(res_vld1), .res(res1),
        .isqrt_x_vld(xv1), .isqrt_x(x1), .isqrt_y_vld(yv1), .isqrt_y(y1)
    );

    always #5 clk = ~clk;

    // Largest r with r*r <= x, found by binary search.
    function automatic logic [15:0] isqrt32(input logic [31:0] x);
        longint lo = 0;
        longint hi = 65535;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid - 1;
        end
        return 16'(lo);
    endfunction

    // Direct evaluation of the nested or summed formula over n words.
    function automatic logic [31:0] ref_model(input logic [95:0] a, input int n, input logic m);
        logic [31:0] v;
        if (m) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v + 32'(isqrt32(a[i*32 +: 32]));
        end else begin
            v = 32'(isqrt32(a[(n-1)*32 +: 32]));
            for (int i = n - 2; i >= 0; i--) v = 32'(isqrt32(a[i*32 +: 32] + v));
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural isqrt units: one response per request after lat cycles, cleared by reset.
    always begin
        @(posedge clk);
        if (rst) begin
            pend3 = 1'b0;
            pend1 = 1'b0;
        end else begin
            if (yv3) pend3 = 1'b0;
            if (xv3) begin
                checkOutput("single_outstanding_n3", {31'b0, pend3}, 32'd0);
                pend3 = 1'b1;
                due3  = cyc + lat3;
                val3  = isqrt32(x3);
                if (req_cnt3 < 8) req_log3[req_cnt3] = x3;
                req_cnt3++;
            end
            if (yv1) pend1 = 1'b0;
            if (xv1) begin
                checkOutput("single_outstanding_n1", {31'b0, pend1}, 32'd0);
                pend1 = 1'b1;
                due1  = cyc + lat1;
                val1  = isqrt32(x1);
            end
        end
        cyc++;
        #1;
        yv3 = pend3 && (due3 == cyc);
        y3  = yv3 ? val3 : 16'($urandom);
        yv1 = pend1 && (due1 == cyc);
        y1  = yv1 ? val1 : 16'($urandom);
    end

    task automatic applyStimulus(input int n, input logic [95:0] a, input logic m, input int lat);
        int waited = 0;
        while (!((n == 3) ? arg_rdy3 : arg_rdy1) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_accept", {31'b0, (n == 3) ? arg_rdy3 : arg_rdy1}, 32'd1);
        if (n == 3) begin
            lat3 = lat; args3 = a; mode3 = m; arg_vld3 = 1'b1; req_cnt3 = 0;
        end else begin
            lat1 = lat; args1 = a[31:0]; mode1 = m; arg_vld1 = 1'b1;
        end
        t_acc = cyc;
        @(negedge clk);
        arg_vld3 = 1'b0;
        arg_vld1 = 1'b0;
    endtask

    task automatic wait_res(input int n, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 300; i++) begin
            if ((n == 3) ? res_vld3 : res_vld1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_set(input int n, input logic [95:0] a, input logic m, input int lat,
                           input logic [31:0] exp, input string tag);
        int at;
        bit ok;
        applyStimulus(n, a, m, lat);
        wait_res(n, at, ok);
        checkOutput({tag, "_done"}, {31'b0, ok}, 32'd1);
        if (ok) begin
            checkOutput({tag, "_res"}, (n == 3) ? res3 : res1, exp);
            checkOutput({tag, "_latency"}, 32'(at - t_acc), 32'(n * lat + 1));
            checkOutput({tag, "_rdy_with_res"}, {31'b0, (n == 3) ? arg_rdy3 : arg_rdy1}, 32'd1);
            @(negedge clk);
            checkOutput({tag, "_single_pulse"}, {31'b0, (n == 3) ? res_vld3 : res_vld1}, 32'd0);
        end
    endtask

    task automatic check_reqs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2);
        checkOutput({tag, "_req_count"}, 32'(req_cnt3), 32'd3);
        checkOutput({tag, "_req0"}, req_log3[0], e0);
        checkOutput({tag, "_req1"}, req_log3[1], e1);
        checkOutput({tag, "_req2"}, req_log3[2], e2);
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by randomized sets.
    initial begin
        int          at, t2, seen, guard;
        bit          ok;
        logic [95:0] ra;
        logic        rm;
        int          rl;

        rst = 1'b1;
        arg_vld3 = 1'b0; mode3 = 1'b0; args3 = '0;
        arg_vld1 = 1'b0; mode1 = 1'b0; args1 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_res_vld_n3", {31'b0, res_vld3}, 32'd0);
        checkOutput("reset_res_n3", res3, 32'd0);
        checkOutput("reset_rdy_n3", {31'b0, arg_rdy3}, 32'd1);
        checkOutput("reset_res_vld_n1", {31'b0, res_vld1}, 32'd0);
        checkOutput("reset_rdy_n1", {31'b0, arg_rdy1}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] nested 21,12,16");
        run_set(3, {32'd16, 32'd12, 32'd21}, 1'b0, 2, 32'd5, "nested");
        check_reqs("nested", 32'd16, 32'd16, 32'd25);

        $display("[TB] sum 16,25,36");
        run_set(3, {32'd36, 32'd25, 32'd16}, 1'b1, 3, 32'd15, "sum");
        check_reqs("sum", 32'd36, 32'd25, 32'd16);

        $display("[TB] nested wrap all ones");
        run_set(3, {3{32'hFFFF_FFFF}}, 1'b0, 1, 32'd15, "wrap");
        check_reqs("wrap", 32'hFFFF_FFFF, 32'h0000_FFFE, 32'h0000_00FE);

        $display("[TB] backpressure");
        applyStimulus(3, {32'd16, 32'd12, 32'd21}, 1'b0, 2);
        arg_vld3 = 1'b1;
        args3 = '0;
        mode3 = 1'b0;
        guard = 0;
        while (!res_vld3 && guard < 100) begin
            checkOutput("bp_busy_rdy", {31'b0, arg_rdy3}, 32'd0);
            @(negedge clk);
            guard++;
        end
        checkOutput("bp_first_done", {31'b0, res_vld3}, 32'd1);
        checkOutput("bp_first_res", res3, 32'd5);
        checkOutput("bp_first_latency", 32'(cyc - t_acc), 32'd7);
        checkOutput("bp_rdy_in_res_cycle", {31'b0, arg_rdy3}, 32'd1);
        checkOutput("bp_second_req_vld", {31'b0, xv3}, 32'd1);
        checkOutput("bp_second_req_x", x3, 32'd0);
        t2 = cyc;
        req_cnt3 = 0;
        @(negedge clk);
        arg_vld3 = 1'b0;
        checkOutput("bp_pulse_ends", {31'b0, res_vld3}, 32'd0);
        checkOutput("bp_second_busy", {31'b0, arg_rdy3}, 32'd0);
        wait_res(3, at, ok);
        checkOutput("bp_second_done", {31'b0, ok}, 32'd1);
        checkOutput("bp_second_res", res3, 32'd0);
        checkOutput("bp_second_latency", 32'(at - t2), 32'd7);
        @(negedge clk);

        $display("[TB] reset mid-operation");
        applyStimulus(3, {32'd16, 32'd12, 32'd21}, 1'b0, 3);
        guard = 0;
        while (req_cnt3 < 2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rst_second_req_seen", 32'(req_cnt3), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_res_vld", {31'b0, res_vld3}, 32'd0);
        checkOutput("rst_res_cleared", res3, 32'd0);
        checkOutput("rst_rdy", {31'b0, arg_rdy3}, 32'd1);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (res_vld3) seen++;
        end
        checkOutput("rst_no_result", 32'(seen), 32'd0);
        run_set(3, {32'd36, 32'd25, 32'd16}, 1'b1, 3, 32'd15, "after_rst");

        $display("[TB] N=1 build");
        run_set(1, 96'd100, 1'b0, 3, 32'd10, "n1_nested");
        run_set(1, 96'd100, 1'b1, 5, 32'd10, "n1_sum");

        $display("[TB] random sets");
        for (int k = 0; k < 1000; k++) begin
            for (int j = 0; j < 3; j++) begin
                ra[j*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 5000));
            end
            rm = 1'($urandom_range(0, 1));
            rl = $urandom_range(1, 8);
            run_set(3, ra, rm, rl, ref_model(ra, 3, rm), "rand_n3");
        end
        for (int k = 0; k < 100; k++) begin
            ra = {64'd0, 32'($urandom)};
            rm = 1'($urandom_range(0, 1));
            rl = $urandom_range(1, 8);
            run_set(1, ra, rm, rl, ref_model(ra, 1, rm), "rand_n1");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
